// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serialises a captured pattern MSB-first (within the
// effective length), repeats it rep+1 times with GAP idle cycles between
// repetitions, then emits a one-cycle done pulse. All outputs are registered,
// so the next-state logic also computes the value each output takes next cycle.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       len,
  input  logic [3:0]       rep,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP, ST_DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] pat_q, pat_nx;
  logic [3:0]       len_q, len_nx;
  logic [3:0]       rep_cnt, rep_nx;   // repetitions still to start after this one
  logic [3:0]       bit_cnt, bit_nx;   // index of the bit currently on dout
  logic [3:0]       gap_cnt, gap_nx;   // idle cycles left after this one
  logic             dout_nx, dv_nx, done_nx;
  logic [3:0]       len_eff;

  // Select one pattern bit by a 4-bit index without a width-mismatched select.
  function automatic logic bit_of(input logic [WIDTH-1:0] p, input logic [3:0] idx);
    logic [WIDTH-1:0] s;
    s = p >> idx;
    return s[0];
  endfunction

  // len of 0 or beyond the register width means "whole register".
  assign len_eff  = (len == 4'd0 || len > 4'(WIDTH)) ? 4'(WIDTH) : len;
  assign in_ready = (state == ST_IDLE) && !abort;
  assign busy     = (state != ST_IDLE);

  // Next state plus the registered output values for the coming cycle.
  always_comb begin
    state_nx = state;
    pat_nx   = pat_q;
    len_nx   = len_q;
    rep_nx   = rep_cnt;
    bit_nx   = bit_cnt;
    gap_nx   = gap_cnt;
    dout_nx  = 1'b0;
    dv_nx    = 1'b0;
    done_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          pat_nx   = pattern;
          len_nx   = len_eff;
          rep_nx   = rep;
          bit_nx   = len_eff - 4'd1;
          dout_nx  = bit_of(pattern, len_eff - 4'd1);
          dv_nx    = 1'b1;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt != 4'd0) begin
          bit_nx  = bit_cnt - 4'd1;
          dout_nx = bit_of(pat_q, bit_cnt - 4'd1);
          dv_nx   = 1'b1;
        end else if (rep_cnt != 4'd0) begin
          if (GAP > 0) begin
            gap_nx   = 4'(GAP - 1);
            state_nx = ST_GAP;
          end else begin
            // No gap: next repetition's first bit follows without a bubble.
            rep_nx  = rep_cnt - 4'd1;
            bit_nx  = len_q - 4'd1;
            dout_nx = bit_of(pat_q, len_q - 4'd1);
            dv_nx   = 1'b1;
          end
        end else begin
          done_nx  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == 4'd0) begin
          rep_nx   = rep_cnt - 4'd1;
          bit_nx   = len_q - 4'd1;
          dout_nx  = bit_of(pat_q, len_q - 4'd1);
          dv_nx    = 1'b1;
          state_nx = ST_SHIFT;
        end else begin
          gap_nx = gap_cnt - 4'd1;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    // Cancel wins over everything once a transfer is in flight.
    if (abort && state != ST_IDLE) begin
      state_nx = ST_IDLE;
      dout_nx  = 1'b0;
      dv_nx    = 1'b0;
      done_nx  = 1'b0;
    end
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pat_q      <= '0;
      len_q      <= '0;
      rep_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      pat_q      <= pat_nx;
      len_q      <= len_nx;
      rep_cnt    <= rep_nx;
      bit_cnt    <= bit_nx;
      gap_cnt    <= gap_nx;
      dout       <= dout_nx;
      dout_valid <= dv_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: one GAP=1 and one GAP=0 instance share stimulus;
// a queue-based stream model, a vector table and hand sequences check them.
module tb_seq_pattern_tx;

  logic       clk, rst, in_valid, abort;
  logic [7:0] pattern;
  logic [3:0] len, rep;
  logic       ready_a, dout_a, dv_a, busy_a, done_a;
  logic       ready_b, dout_b, dv_b, busy_b, done_b;
  logic [4:0] out_a, out_b;

  int n_checks = 0;
  int n_err    = 0;

  seq_pattern_tx #(.WIDTH(8), .GAP(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a),
    .pattern(pattern), .len(len), .rep(rep), .abort(abort),
    .dout(dout_a), .dout_valid(dv_a), .busy(busy_a), .done(done_a));

  seq_pattern_tx #(.WIDTH(8), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_b),
    .pattern(pattern), .len(len), .rep(rep), .abort(abort),
    .dout(dout_b), .dout_valid(dv_b), .busy(busy_b), .done(done_b));

  // {in_ready, busy, dout_valid, dout, done}
  assign out_a = {ready_a, busy_a, dv_a, dout_a, done_a};
  assign out_b = {ready_b, busy_b, dv_b, dout_b, done_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef logic [4:0] q_t[$];

  // Expected per-cycle outputs after acceptance, straight from the rules:
  // L bits per repetition, gap idle cycles between repetitions, then done.
  function automatic q_t model(input logic [7:0] p, input logic [3:0] l,
                               input logic [3:0] r, input int gap);
    q_t q;
    int L;
    L = (l == 0 || l > 8) ? 8 : int'(l);
    for (int k = 0; k <= int'(r); k++) begin
      for (int i = L - 1; i >= 0; i--) q.push_back({3'b011, p[i], 1'b0});
      if (k < int'(r)) repeat (gap) q.push_back(5'b01000);
    end
    q.push_back(5'b01001);
    return q;
  endfunction

  // One transfer from idle; checks both instances every cycle against the model.
  task automatic xfer(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                      output int dca, output int dcb, output logic [15:0] bits, output int nb);
    q_t qa, qb;
    logic [4:0] ea, eb;
    int cyc;
    qa = model(p, l, r, 1);
    qb = model(p, l, r, 0);
    pattern = p; len = l; rep = r; in_valid = 1'b1;
    #1;
    check("accept_ready", {14'd0, ready_a, ready_b}, 16'h3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    pattern = 8'($urandom); len = 4'($urandom); rep = 4'($urandom);
    cyc = 0; dca = 0; dcb = 0; bits = '0; nb = 0;
    while (qa.size() > 0 || qb.size() > 0) begin
      cyc++;
      ea = (qa.size() > 0) ? qa.pop_front() : 5'b10000;
      eb = (qb.size() > 0) ? qb.pop_front() : 5'b10000;
      check("stream_a", {11'd0, out_a}, {11'd0, ea});
      check("stream_b", {11'd0, out_b}, {11'd0, eb});
      if (done_a) dca = cyc;
      if (done_b) dcb = cyc;
      if (dv_a) begin bits = {bits[14:0], dout_a}; nb++; end
      @(posedge clk); #1;
    end
    check("idle_after", {12'd0, ready_a, busy_a, ready_b, busy_b}, 16'ha);
  endtask

  typedef struct {
    logic [7:0]  p;
    logic [3:0]  l;
    logic [3:0]  r;
    int          nbits;
    logic [15:0] bits;
    int          done_a;
    int          done_b;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int dca, dcb, nb;
    logic [15:0] bits;
    logic [4:0] seq_exp[7];

    tbl[0] = '{8'h05, 4'd3,  4'd0,  3,  16'h0005, 4,  4};
    tbl[1] = '{8'h05, 4'd3,  4'd2,  9,  16'h016D, 12, 10};
    tbl[2] = '{8'hA5, 4'd0,  4'd0,  8,  16'h00A5, 9,  9};
    tbl[3] = '{8'hA5, 4'd9,  4'd0,  8,  16'h00A5, 9,  9};
    tbl[4] = '{8'hFF, 4'd1,  4'd3,  4,  16'h000F, 8,  5};
    tbl[5] = '{8'h80, 4'd8,  4'd0,  8,  16'h0080, 9,  9};
    tbl[6] = '{8'h02, 4'd2,  4'd1,  4,  16'h000A, 6,  5};
    tbl[7] = '{8'h01, 4'd1,  4'd15, 16, 16'hFFFF, 32, 17};

    // Reset state, including in_ready masking by abort.
    rst = 1'b0; in_valid = 1'b0; abort = 1'b1; pattern = '0; len = '0; rep = '0;
    #2;
    check("reset_abort", {11'd0, out_a}, 16'h0000);
    abort = 1'b0;
    #2;
    check("reset_a", {11'd0, out_a}, 16'h0010);
    check("reset_b", {11'd0, out_b}, 16'h0010);
    #8 rst = 1'b1;
    @(posedge clk); #1;

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      xfer(tbl[i].p, tbl[i].l, tbl[i].r, dca, dcb, bits, nb);
      check("tbl_bits",   bits, tbl[i].bits);
      check("tbl_nbits",  16'(nb), 16'(tbl[i].nbits));
      check("tbl_done_a", 16'(dca), 16'(tbl[i].done_a));
      check("tbl_done_b", 16'(dcb), 16'(tbl[i].done_b));
    end

    // Back-to-back: in_valid held, len=2 rep=0 pattern 10.
    seq_exp = '{5'b01110, 5'b01100, 5'b01001, 5'b10000, 5'b01110, 5'b01100, 5'b01001};
    pattern = 8'h02; len = 4'd2; rep = 4'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 7; c++) begin
      check("b2b_a", {11'd0, out_a}, {11'd0, seq_exp[c]});
      check("b2b_b", {11'd0, out_b}, {11'd0, seq_exp[c]});
      if (c == 4) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b_idle", {11'd0, out_a}, 16'h0010);

    // Abort mid-shift of a len=8 transfer.
    pattern = 8'hA5; len = 4'd8; rep = 4'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_c1", {11'd0, out_a}, 16'h000E);
    @(posedge clk); #1;
    check("abort_c2", {11'd0, out_a}, 16'h000C);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    #1;
    check("abort_c3_a", {11'd0, out_a}, 16'h0010);
    check("abort_c3_b", {11'd0, out_b}, 16'h0010);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check("abort_quiet", {6'd0, out_a, out_b}, {6'd0, 5'b10000, 5'b10000});
    end

    // Abort in IDLE blocks acceptance only.
    abort = 1'b1; in_valid = 1'b1;
    #1;
    check("idle_abort_ready", {14'd0, ready_a, ready_b}, 16'h0);
    @(posedge clk); #1;
    check("idle_abort_stay", {11'd0, out_a}, 16'h0000);
    abort = 1'b0; in_valid = 1'b0;
    #1;

    // Asynchronous reset mid-shift, then a fresh transfer.
    pattern = 8'hA5; len = 4'd8; rep = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", {14'd0, busy_a, busy_b}, 16'h3);
    #3 rst = 1'b0;
    #1;
    check("async_rst_a", {11'd0, out_a}, 16'h0010);
    check("async_rst_b", {11'd0, out_b}, 16'h0010);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {11'd0, out_a}, 16'h0010);
    xfer(8'h5A, 4'd0, 4'd0, dca, dcb, bits, nb);
    check("post_rst_bits", bits, 16'h005A);
    check("post_rst_done", 16'(dca), 16'd9);

    // Randomized transfers against the model.
    for (int i = 0; i < 25; i++) begin
      xfer(8'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
           dca, dcb, bits, nb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
